// File: rtl/uart_msg_tx.sv
// ============================================================================
// Module      : uart_msg_tx
// Description : Reports a 6-bit value as "TU\r\n" over an 8N1 UART line.
//               Optional even-parity frame bit: define UART_MSG_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_msg_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Send,
    input  logic [5:0] i_Value,
    output logic       o_TX_Serial,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Overrun
);

    localparam int              CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_MSG_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [1:0]       byte_idx;
    logic [1:0]       byte_idx_next;
    logic [2:0]       tens;
    logic [2:0]       tens_next;
    logic [3:0]       ones;
    logic [3:0]       ones_next;
    logic [6:0]       split_val;
    logic [7:0]       tx_byte;
    logic             bit_end;
    logic             tx_next;
    logic             busy_next;
    logic             done_next;

    // Repeated compare-subtract of ten; six steps cover the full 0..63 range.
    function automatic logic [6:0] split_digits(input logic [5:0] v);
        logic [5:0] rem;
        logic [2:0] t;
        rem = v;
        t   = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (rem >= 6'd10) begin
                rem = rem - 6'd10;
                t   = t + 3'd1;
            end
        end
        return {t, rem[3:0]};
    endfunction

    function automatic logic [7:0] msg_byte(input logic [1:0] idx,
                                            input logic [2:0] t,
                                            input logic [3:0] o);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {5'b00110, t};
            2'd1:    b = {4'h3, o};
            2'd2:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    assign bit_end   = (cnt == CNT_MAX);
    assign split_val = split_digits(i_Value);

    // State register
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_Send) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_MSG_TX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_MSG_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_next = (byte_idx == 2'd3) ? S_IDLE : S_START;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bit-period counter, indices and digit capture
    always_comb begin
        cnt_next      = cnt;
        bit_idx_next  = bit_idx;
        byte_idx_next = byte_idx;
        tens_next     = tens;
        ones_next     = ones;
        if (state == S_IDLE) begin
            cnt_next      = '0;
            bit_idx_next  = 3'd0;
            byte_idx_next = 2'd0;
            if (i_Send) begin
                tens_next = split_val[6:4];
                ones_next = split_val[3:0];
            end
        end else begin
            cnt_next = bit_end ? '0 : cnt + 1'b1;
            if (bit_end && (state == S_DATA)) begin
                bit_idx_next = bit_idx + 3'd1;
            end
            if (bit_end && (state == S_STOP)) begin
                byte_idx_next = byte_idx + 2'd1;
            end
        end
    end

    // Output logic: line level is computed for the upcoming cycle and registered
    always_comb begin
        tx_byte   = msg_byte(byte_idx_next, tens, ones);
        tx_next   = 1'b1;
        busy_next = (state_next != S_IDLE);
        done_next = (state == S_STOP) && bit_end && (byte_idx == 2'd3);
        o_Overrun = i_Send && (state != S_IDLE);
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = tx_byte[bit_idx_next];
`ifdef UART_MSG_TX_PARITY_EN
            S_PARITY: tx_next = ^tx_byte;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            cnt         <= '0;
            bit_idx     <= 3'd0;
            byte_idx    <= 2'd0;
            tens        <= 3'd0;
            ones        <= 4'd0;
            o_TX_Serial <= 1'b1;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            bit_idx     <= bit_idx_next;
            byte_idx    <= byte_idx_next;
            tens        <= tens_next;
            ones        <= ones_next;
            o_TX_Serial <= tx_next;
            o_Busy      <= busy_next;
            o_Done      <= done_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_msg_tx.sv
// ============================================================================
// Module      : tb_uart_msg_tx
// Description : Self-checking bench for uart_msg_tx against a message model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_msg_tx;

    localparam int CPB = 23;
`ifdef UART_MSG_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int NBITS = 4 * FRAME;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [5:0] value;
    logic       tx;
    logic       busy;
    logic       done;
    logic       ovr;

    int n_cmp = 0;
    int n_err = 0;
    int ovr_cnt = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    logic exp_bits [0:NBITS-1];

    uart_msg_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Send      (send),
        .i_Value     (value),
        .o_TX_Serial (tx),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Overrun   (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ovr === 1'b1) ovr_cnt++;
        if (done === 1'b1) done_cnt++;
        if (done === 1'b1 && ovr === 1'b1) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line sequence for one message, from the textual rules only
    task automatic build_frame(input int v);
        logic [7:0] m [4];
        int n;
        m[0] = 8'(48 + v / 10);
        m[1] = 8'(48 + v % 10);
        m[2] = 8'h0D;
        m[3] = 8'h0A;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            exp_bits[n] = 1'b0; n++;
            for (int b = 0; b < 8; b++) begin
                exp_bits[n] = m[i][b]; n++;
            end
`ifdef UART_MSG_TX_PARITY_EN
            exp_bits[n] = ^m[i]; n++;
`endif
            exp_bits[n] = 1'b1; n++;
        end
    endtask

    // Sends one message and checks every bit slot; ovr_at/chg_at/abort_at are
    // cycle offsets after accept (-1 disables them).
    task automatic send_msg(input int v, input bit hold, input int ovr_at,
                            input int chg_at, input int abort_at);
        int hold_err;
        int ovr_base;
        string tag;
        build_frame(v);
        ovr_base = ovr_cnt;
        hold_err = 0;
        value = 6'(v);
        send  = 1'b1;
        tick();
        if (!hold) send = 1'b0;
        check($sformatf("accept_busy v=%0d", v), {31'd0, busy}, 1);
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                int cyc;
                cyc = b * CPB + c;
                if (cyc == abort_at) return;
                if (c == 0) begin
                    tag = $sformatf("line v=%0d bit%0d", v, b);
                    check(tag, {31'd0, tx}, {31'd0, exp_bits[b]});
                end else if (tx !== exp_bits[b]) begin
                    hold_err++;
                end
                if (busy !== 1'b1 || done !== 1'b0) hold_err++;
                if (!hold) send = 1'b0;
                if (cyc == ovr_at) begin
                    send = 1'b1;
                    #1;
                    check("overrun_pulse", {31'd0, ovr}, 1);
                end
                if (cyc == chg_at) value = 6'($urandom_range(63));
                tick();
            end
        end
        check($sformatf("bit_hold v=%0d", v), hold_err, 0);
        check($sformatf("done v=%0d", v), {31'd0, done}, 1);
        check($sformatf("done_busy v=%0d", v), {31'd0, busy}, 0);
        check($sformatf("done_line v=%0d", v), {31'd0, tx}, 1);
        check("done_no_overrun", {31'd0, ovr}, 0);
        check($sformatf("overrun_count v=%0d", v), ovr_cnt - ovr_base,
              hold ? NBITS * CPB : (ovr_at >= 0 ? 1 : 0));
        if (!hold) begin
            send = 1'b0;
            tick();
            check("done_one_cycle", {31'd0, done}, 0);
        end
    endtask

    initial begin
        int dbase;
        int obase;
        rst   = 1'b1;
        send  = 1'b0;
        value = 6'd0;
        tick();
        tick();
        check("reset_line", {31'd0, tx}, 1);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_overrun", {31'd0, ovr}, 0);
        rst = 1'b0;
        tick();

        send_msg(7, 1'b0, -1, -1, -1);
        send_msg(59, 1'b0, -1, -1, -1);
        send_msg(60, 1'b0, -1, -1, -1);
        send_msg(63, 1'b0, -1, -1, -1);
        send_msg(0, 1'b0, -1, -1, -1);

        send_msg(int'($urandom_range(63)), 1'b0, 13 * CPB + 5, 20 * CPB + 3, -1);

        send_msg(int'($urandom_range(63)), 1'b1, -1, -1, -1);
        send_msg(int'($urandom_range(63)), 1'b0, -1, -1, -1);

        // Abort during byte 2 data bits, with a request pending under reset
        dbase = done_cnt;
        send_msg(int'($urandom_range(63)), 1'b0, -1, -1, (2 * FRAME + 3) * CPB + 5);
        obase = ovr_cnt;
        rst = 1'b1;
        #1;
        send = 1'b1;
        #1;
        check("midreset_line", {31'd0, tx}, 1);
        check("midreset_busy", {31'd0, busy}, 0);
        check("midreset_overrun", {31'd0, ovr}, 0);
        tick();
        tick();
        send = 1'b0;
        rst  = 1'b0;
        tick();
        check("midreset_no_done", done_cnt - dbase, 0);
        check("midreset_no_overrun", ovr_cnt - obase, 0);
        send_msg(int'($urandom_range(63)), 1'b0, -1, -1, -1);

        for (int i = 0; i < 3; i++) begin
            send_msg(int'($urandom_range(63)), 1'b0, -1, int'($urandom_range(NBITS * CPB - 1)), -1);
        end

        check("done_overrun_exclusive", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
